// File: rtl/id_ex_ctl_pipe.sv
// id_ex_ctl_pipe -- ID/EX pipeline register with load-use hazard detection.
//
// Captures the decoded control bundle, register addresses, funct3, PC and
// immediate from ID and presents them to EX one cycle later. A load in EX
// whose destination is read by the instruction in ID stalls IF/ID for one
// cycle and sends a bubble (all-zero bundle) into EX. flush_i kills the EX
// contents; hold_i freezes them.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   id_valid_i            ID holds a real instruction
//   *_ctl_i               decoder control fields (pc_sel, op1sel, op2sel,
//                         wb_sel, pc4_sel, mem_wr, cpr_en, rf_en, alu_fun)
//   id_funct3_i, id_rd_i, id_rs1_i, id_rs2_i, id_rs*_used_i, id_pc_i, id_imm_i
//   flush_i               EX redirect: EX register loads a bubble
//   hold_i                downstream stall: EX register keeps its value
//   ex_*_o                registered bundle presented to EX
//   stall_id_o            IF/ID must hold this cycle
//   bubble_cnt_o          count of load-use bubbles
//
// Configuration macro: ID_EX_BUBBLE_CNT_EN -- when defined, bubble_cnt_o is a
// free-running 32-bit count of load-use bubbles; otherwise it is tied to 0.
module id_ex_ctl_pipe #(
  parameter int PC_W = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            id_valid_i,
  input  logic [1:0]      pc_sel_ctl_i,
  input  logic            op1sel_ctl_i,
  input  logic [1:0]      op2sel_ctl_i,
  input  logic [1:0]      wb_sel_ctl_i,
  input  logic            pc4_sel_ctl_i,
  input  logic            mem_wr_ctl_i,
  input  logic            cpr_en_ctl_i,
  input  logic            rf_en_ctl_i,
  input  logic [5:0]      alu_fun_ctl_i,
  input  logic [2:0]      id_funct3_i,
  input  logic [RA_W-1:0] id_rd_i,
  input  logic [RA_W-1:0] id_rs1_i,
  input  logic [RA_W-1:0] id_rs2_i,
  input  logic            id_rs1_used_i,
  input  logic            id_rs2_used_i,
  input  logic [PC_W-1:0] id_pc_i,
  input  logic [PC_W-1:0] id_imm_i,
  input  logic            flush_i,
  input  logic            hold_i,
  output logic            ex_valid_o,
  output logic [1:0]      ex_pc_sel_o,
  output logic            ex_op1sel_o,
  output logic [1:0]      ex_op2sel_o,
  output logic [1:0]      ex_wb_sel_o,
  output logic            ex_pc4_sel_o,
  output logic            ex_mem_wr_o,
  output logic            ex_cpr_en_o,
  output logic            ex_rf_en_o,
  output logic [5:0]      ex_alu_fun_o,
  output logic [2:0]      ex_funct3_o,
  output logic [RA_W-1:0] ex_rd_o,
  output logic [RA_W-1:0] ex_rs1_o,
  output logic [RA_W-1:0] ex_rs2_o,
  output logic [PC_W-1:0] ex_pc_o,
  output logic [PC_W-1:0] ex_imm_o,
  output logic            stall_id_o,
  output logic [31:0]     bubble_cnt_o
);

  // Whole EX bundle kept as one vector so a bubble is simply all-zero.
  localparam int BW = 1 + 2 + 1 + 2 + 2 + 1 + 1 + 1 + 1 + 6 + 3 + 3*RA_W + 2*PC_W;

  logic [BW-1:0] id_bundle;
  logic [BW-1:0] ex_q, ex_d;
  logic          load_use;
  logic          rs1_hit, rs2_hit;

  assign id_bundle = {id_valid_i, pc_sel_ctl_i, op1sel_ctl_i, op2sel_ctl_i,
                      wb_sel_ctl_i, pc4_sel_ctl_i, mem_wr_ctl_i, cpr_en_ctl_i,
                      rf_en_ctl_i, alu_fun_ctl_i, id_funct3_i, id_rd_i,
                      id_rs1_i, id_rs2_i, id_pc_i, id_imm_i};

  assign {ex_valid_o, ex_pc_sel_o, ex_op1sel_o, ex_op2sel_o, ex_wb_sel_o,
          ex_pc4_sel_o, ex_mem_wr_o, ex_cpr_en_o, ex_rf_en_o, ex_alu_fun_o,
          ex_funct3_o, ex_rd_o, ex_rs1_o, ex_rs2_o, ex_pc_o, ex_imm_o} = ex_q;

  // A load in EX (wb_sel 00) writing a non-zero rd read by the ID instruction.
  assign rs1_hit  = id_rs1_used_i && (id_rs1_i == ex_rd_o);
  assign rs2_hit  = id_rs2_used_i && (id_rs2_i == ex_rd_o);
  assign load_use = ex_valid_o && ex_rf_en_o && (ex_wb_sel_o == 2'b00) &&
                    (ex_rd_o != '0) && id_valid_i && (rs1_hit || rs2_hit);

  assign stall_id_o = !flush_i && (hold_i || load_use);

  always_comb begin
    ex_d = ex_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (hold_i) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d = '0;
    end else if (id_valid_i) begin
      ex_d = id_bundle;
    end else begin
      ex_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Only load-use bubbles count; flush and hold take priority over them.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!flush_i && !hold_i && load_use) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: doc/id_ex_ctl_pipe.md
Name: id_ex_ctl_pipe

Overview:
- ID/EX pipeline register for the RISC-V pipeline; sits directly downstream of the combinational control decoder.
- Captures the decoded control bundle, register addresses, funct3, PC and immediate each cycle, and presents them to the EX stage.
- Contains load-use hazard detection: when needed, it stalls IF/ID and inserts a bubble into EX.
- Handles pipeline flush on EX redirect and external hold from the memory side.

Parameters:
PC_W, 32, width of PC and immediate fields
RA_W, 5, register address width

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous active-high reset
id_valid_i  input  1  ID holds a real instruction
pc_sel_ctl_i  input  2  decoder pc_sel
op1sel_ctl_i  input  1  decoder op1sel
op2sel_ctl_i  input  2  decoder op2sel
wb_sel_ctl_i  input  2  decoder wb_sel (00 = load data)
pc4_sel_ctl_i  input  1  decoder pc4_sel
mem_wr_ctl_i  input  1  decoder mem_wr
cpr_en_ctl_i  input  1  decoder cpr_en
rf_en_ctl_i  input  1  decoder rf_en
alu_fun_ctl_i  input  6  decoder alu_fun
id_funct3_i  input  3  instruction funct3
id_rd_i  input  RA_W  destination register
id_rs1_i  input  RA_W  source 1
id_rs2_i  input  RA_W  source 2
id_rs1_used_i  input  1  ID reads rs1
id_rs2_used_i  input  1  ID reads rs2
id_pc_i  input  PC_W  ID PC
id_imm_i  input  PC_W  sign-extended immediate
flush_i  input  1  EX redirect; kill ID and EX contents
hold_i  input  1  downstream stall; freeze EX register
ex_valid_o  output  1  EX holds a real instruction
ex_pc_sel_o ... ex_alu_fun_o  output  (widths as inputs)  registered control bundle, one port per field
ex_funct3_o  output  3  registered funct3
ex_rd_o, ex_rs1_o, ex_rs2_o  output  RA_W  registered addresses
ex_pc_o, ex_imm_o  output  PC_W  registered PC and immediate
stall_id_o  output  1  IF/ID must hold this cycle
bubble_cnt_o  output  32  inserted-bubble count (see Optional Feature)

Behaviour:
- Reset (async, immediate): every ex_* output and ex_valid_o = 0; bubble_cnt_o = 0. stall_id_o is combinational and is therefore 0 while the EX register is empty.
- Bubble definition: ex_valid_o = 0 and all control fields = 0. This gives rf_en = 0, mem_wr = 0, cpr_en = 0 and pc_sel = 00. Address, PC and immediate fields are also zeroed.
- load_use (combinational) = ex_valid_o & ex_rf_en_o & (ex_wb_sel_o == 2'b00) & ex_rd_o != 0 & id_valid_i & ((id_rs1_used_i & id_rs1_i == ex_rd_o) | (id_rs2_used_i & id_rs2_i == ex_rd_o)).
- stall_id_o = !flush_i & (hold_i | load_use).
- Register update at posedge clk, priority highest first:
  1. flush_i: EX register loads a bubble. hold_i and load_use are ignored.
  2. hold_i: EX register keeps its value.
  3. load_use: EX register loads a bubble; the bubble counter increments.
  4. Otherwise: EX register captures the ID inputs; ex_valid_o = id_valid_i.
- id_valid_i = 0 on a normal cycle: controls are captured but forced to bubble values.
- Load-use stall lasts exactly 1 cycle: after the bubble, the load has left EX and the ID instruction advances on the next edge.
- hold_i while a load sits in EX with a dependent instruction in ID: the register is held, no bubble is inserted and the counter is not incremented. The bubble is inserted on the first cycle hold_i drops.
- Reset asserted mid-stall: the register clears immediately and stall_id_o deasserts in the same cycle.
- Latency: ID to EX is 1 cycle. No combinational path from the ID inputs to any ex_* output.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined: bubble_cnt_o is a 32-bit counter. It increments by 1 on each load_use bubble insertion (priority case 3 only), wraps 0xFFFFFFFF -> 0, and clears on reset. Flush bubbles are not counted.
- Not defined: bubble_cnt_o is tied to 0 and no counter flops exist.

Test Plan:
- Reset mid-operation with valid data in EX -> all ex_* outputs are 0 and stall_id_o = 0 in the same cycle, before any clock edge.
- ADD x3,x1,x2 in ID, no hazard -> next cycle ex_rf_en_o = 1, ex_alu_fun_o = 6'b000000, ex_op2sel_o = 2'b11, ex_rd_o = 3, ex_valid_o = 1.
- LW x5 in EX; ADDI x6,x5,4 in ID (rs1_used = 1) -> stall_id_o = 1 for exactly 1 cycle; a bubble enters EX; the ADDI enters EX next; bubble_cnt_o = 1 (macro defined).
- LW x0 in EX; consumer of x0 in ID -> stall_id_o = 0 and no bubble.
- flush_i and load_use together -> bubble enters EX, stall_id_o = 0, bubble_cnt_o unchanged.
- hold_i = 1 for 3 cycles with SW in EX -> ex_mem_wr_o = 1 and all EX outputs stable for the 3 cycles; stall_id_o = 1 for the 3 cycles.
